disk_track_loader: RTL and testbench

DISK_TRACK_LOADER -- requirements
Module: disk_track_loader

---
 rtl/disk_track_loader_if.sv | 29 ++
 rtl/disk_track_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_disk_track_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disk_track_loader_if.sv
// Bus between the floppy track loader and its host: drive status in, SD sector
// requests out. The loader connects through the master modport.
interface disk_track_loader_if #(
    parameter int DRIVES  = 2,
    parameter int TRACK_W = 6
);
    logic [DRIVES*TRACK_W-1:0] track;
    logic [DRIVES-1:0]         img_mounted;
    logic [DRIVES-1:0]         img_valid;
    logic [DRIVES-1:0]         dirty_set;
    logic [DRIVES-1:0]         sd_rd;
    logic [DRIVES-1:0]         sd_wr;
    logic [DRIVES-1:0]         sd_ack;
    logic [31:0]               sd_lba;
    logic [3:0]                track_sec;
    logic [1:0]                track_drive;
    logic                      cpu_wait;
    logic                      busy;

    modport master (
        input  track, img_mounted, img_valid, dirty_set, sd_ack,
        output sd_rd, sd_wr, sd_lba, track_sec, track_drive, cpu_wait, busy
    );

    modport slave (
        output track, img_mounted, img_valid, dirty_set, sd_ack,
        input  sd_rd, sd_wr, sd_lba, track_sec, track_drive, cpu_wait, busy
    );
endinterface

// File: rtl/disk_track_loader.sv
// Floppy track cache loader: writes back a dirty track and reads the head's new
// track from SD, one drive at a time, stalling the CPU while it does so.
module disk_track_drive #(
    parameter int TRACK_W = 6
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               mounted,
    input  logic               dirty_set,
    input  logic               reading,
    input  logic               upd_track,
    input  logic               clr_mount,
    input  logic               clr_dirty,
    input  logic [TRACK_W-1:0] track,
    output logic [TRACK_W-1:0] cur_track,
    output logic               dirty,
    output logic               mount_pend
);
    // Host pulses take priority over the loader's clears so no event is lost.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cur_track  <= '0;
            dirty      <= 1'b0;
            mount_pend <= 1'b0;
        end else begin
            if (upd_track) cur_track <= track;
            if (mounted)        mount_pend <= 1'b1;
            else if (clr_mount) mount_pend <= 1'b0;
            if (mounted)                     dirty <= 1'b0;
            else if (dirty_set && !reading)  dirty <= 1'b1;
            else if (clr_dirty)              dirty <= 1'b0;
        end
    end
endmodule

module disk_track_loader #(
    parameter int DRIVES    = 2,
    parameter int SECTORS   = 13,
    parameter int TRACK_W   = 6,
    parameter int WAIT_FULL = 1
) (
    input logic                 clk_sys,
    input logic                 reset,
    disk_track_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t state, state_nx;
    logic [31:0] lba, lba_nx;
    logic [3:0]  sec, sec_nx;
    logic [1:0]  drv, drv_nx;
    logic        rd, rd_nx, wr, wr_nx, wt, wt_nx;
    logic [DRIVES-1:0] ack_q;

    logic [DRIVES-1:0][TRACK_W-1:0] trk, cur_track;
    logic [DRIVES-1:0] dirty, mount_pend, need, reading;
    logic [DRIVES-1:0] upd_track, clr_mount, clr_dirty;

    logic               sel_found, sel_valid, sel_dirty, sel_mount;
    logic [1:0]         sel;
    logic [TRACK_W-1:0] sel_trk, sel_cur, act_trk;
    logic               act_ack, act_ack_q, ack_rise, ack_fall;

    function automatic logic [DRIVES-1:0] onehot(input logic [1:0] i);
        logic [DRIVES-1:0] v;
        v = '0;
        for (int d = 0; d < DRIVES; d++)
            if (i == 2'(d)) v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t);
        return 32'(SECTORS) * 32'(t);
    endfunction

    for (genvar g = 0; g < DRIVES; g++) begin : g_drv
        assign trk[g]     = bus.track[g*TRACK_W +: TRACK_W];
        assign need[g]    = (trk[g] != cur_track[g]) || mount_pend[g];
        assign reading[g] = (state == READ) && (drv == 2'(g));

        disk_track_drive #(.TRACK_W(TRACK_W)) u_drv (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .mounted    (bus.img_mounted[g]),
            .dirty_set  (bus.dirty_set[g]),
            .reading    (reading[g]),
            .upd_track  (upd_track[g]),
            .clr_mount  (clr_mount[g]),
            .clr_dirty  (clr_dirty[g]),
            .track      (trk[g]),
            .cur_track  (cur_track[g]),
            .dirty      (dirty[g]),
            .mount_pend (mount_pend[g])
        );
    end

    // Lowest-index drive needing service wins; the active drive's ack is muxed out.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int d = DRIVES-1; d >= 0; d--)
            if (need[d]) begin
                sel_found = 1'b1;
                sel       = 2'(d);
            end
        sel_valid = 1'b0;
        sel_dirty = 1'b0;
        sel_mount = 1'b0;
        sel_trk   = '0;
        sel_cur   = '0;
        act_trk   = '0;
        act_ack   = 1'b0;
        act_ack_q = 1'b0;
        for (int d = 0; d < DRIVES; d++) begin
            if (sel == 2'(d)) begin
                sel_valid = bus.img_valid[d];
                sel_dirty = dirty[d];
                sel_mount = mount_pend[d];
                sel_trk   = trk[d];
                sel_cur   = cur_track[d];
            end
            if (drv == 2'(d)) begin
                act_trk   = trk[d];
                act_ack   = bus.sd_ack[d];
                act_ack_q = ack_q[d];
            end
        end
    end

    assign ack_rise = act_ack & ~act_ack_q;
    assign ack_fall = ~act_ack & act_ack_q;

    always_comb begin
        state_nx  = state;
        lba_nx    = lba;
        sec_nx    = sec;
        drv_nx    = drv;
        rd_nx     = rd;
        wr_nx     = wr;
        wt_nx     = wt;
        upd_track = '0;
        clr_mount = '0;
        clr_dirty = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    drv_nx = sel;
                    if (!sel_valid) begin
                        upd_track = onehot(sel);
                        clr_mount = onehot(sel);
                        clr_dirty = onehot(sel);
                    end else if (sel_dirty && !sel_mount) begin
                        lba_nx   = lba_of(sel_cur);
                        sec_nx   = '0;
                        wr_nx    = 1'b1;
                        wt_nx    = 1'b1;
                        state_nx = WRITE;
                    end else begin
                        upd_track = onehot(sel);
                        lba_nx    = lba_of(sel_trk);
                        sec_nx    = '0;
                        rd_nx     = 1'b1;
                        wt_nx     = 1'b1;
                        state_nx  = READ;
                    end
                end
            end
            WRITE, READ: begin
                if (ack_rise) begin
                    lba_nx = lba + 32'd1;
                    if (sec == 4'(SECTORS-1)) begin
                        rd_nx = 1'b0;
                        wr_nx = 1'b0;
                    end
                end
                if (ack_fall) begin
                    sec_nx = sec + 4'd1;
                    if (!rd && !wr) begin
                        if (state == WRITE) begin
                            // Write-back done: chain straight into the new track's read.
                            clr_dirty = onehot(drv);
                            upd_track = onehot(drv);
                            lba_nx    = lba_of(act_trk);
                            sec_nx    = '0;
                            rd_nx     = 1'b1;
                            wt_nx     = 1'b1;
                            state_nx  = READ;
                        end else begin
                            clr_mount = onehot(drv);
                            wt_nx     = 1'b0;
                            state_nx  = IDLE;
                        end
                    end else if (state == READ && WAIT_FULL == 0) begin
                        wt_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lba   <= '0;
            sec   <= '0;
            drv   <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            wt    <= 1'b0;
            ack_q <= '0;
        end else begin
            state <= state_nx;
            lba   <= lba_nx;
            sec   <= sec_nx;
            drv   <= drv_nx;
            rd    <= rd_nx;
            wr    <= wr_nx;
            wt    <= wt_nx;
            ack_q <= bus.sd_ack;
        end
    end

    assign bus.sd_rd       = rd ? onehot(drv) : '0;
    assign bus.sd_wr       = wr ? onehot(drv) : '0;
    assign bus.sd_lba      = lba;
    assign bus.track_sec   = sec;
    assign bus.track_drive = drv;
    assign bus.cpu_wait    = wt;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_disk_track_loader.sv
// Randomized scoreboard bench for disk_track_loader: a reference model predicts
// every SD sector transfer, a monitor checks each one as the SD host acks it.
module tb_disk_track_loader;
    localparam int DRV = 2;
    localparam int SEC = 13;
    localparam int TW  = 6;

    typedef struct packed {
        logic        wr;
        logic [1:0]  drv;
        logic [3:0]  sec;
        logic [31:0] lba;
    } xfer_t;

    logic clk_sys, reset;
    disk_track_loader_if #(.DRIVES(DRV), .TRACK_W(TW)) bus();
    disk_track_loader_if #(.DRIVES(1), .TRACK_W(4)) bus2();

    disk_track_loader #(.DRIVES(DRV), .SECTORS(SEC), .TRACK_W(TW), .WAIT_FULL(1)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    disk_track_loader #(.DRIVES(1), .SECTORS(3), .TRACK_W(4), .WAIT_FULL(0)) dut2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus2)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0, n_starts = 0;
    xfer_t sb[$];

    // Reference model state: what each drive holds and what the last transfer left behind.
    int           tr_in[DRV], m_cur[DRV];
    bit           m_dirty[DRV], m_mount[DRV];
    logic [DRV-1:0] m_val;
    logic [31:0]  m_lba;
    logic [3:0]   m_sec;
    logic [1:0]   m_drv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < DRV; d++) begin
            m_cur[d] = 0; m_dirty[d] = 0; m_mount[d] = 0;
        end
        m_lba = '0; m_sec = '0; m_drv = '0;
    endtask

    task automatic push_xfer(input bit wr, input int d, input int trk);
        xfer_t e;
        for (int i = 0; i < SEC; i++) begin
            e.wr = wr; e.drv = 2'(d); e.sec = 4'(i); e.lba = 32'(SEC*trk + i);
            sb.push_back(e);
        end
        m_lba = 32'(SEC*trk + SEC);
        m_sec = 4'(SEC);
    endtask

    task automatic model_service();
        int s;
        do begin
            s = -1;
            for (int d = DRV-1; d >= 0; d--)
                if (tr_in[d] != m_cur[d] || m_mount[d]) s = d;
            if (s >= 0) begin
                m_drv = 2'(s);
                if (m_val[s]) begin
                    if (m_dirty[s] && !m_mount[s]) push_xfer(1'b1, s, m_cur[s]);
                    push_xfer(1'b0, s, tr_in[s]);
                end
                m_cur[s] = tr_in[s]; m_dirty[s] = 0; m_mount[s] = 0;
            end
        end while (s >= 0);
    endtask

    task automatic drive_tracks();
        for (int d = 0; d < DRV; d++) bus.track[d*TW +: TW] = TW'(tr_in[d]);
    endtask

    // Pulses first, then track/valid changes a cycle later, so flags are settled before selection.
    task automatic apply(input logic [DRV-1:0] dm, input logic [DRV-1:0] mm,
                         input int ntr[DRV], input logic [DRV-1:0] nv);
        @(negedge clk_sys);
        bus.dirty_set = dm; bus.img_mounted = mm;
        for (int d = 0; d < DRV; d++) begin
            if (mm[d]) begin m_mount[d] = 1; m_dirty[d] = 0; end
            else if (dm[d]) m_dirty[d] = 1;
        end
        @(negedge clk_sys);
        bus.dirty_set = '0; bus.img_mounted = '0;
        for (int d = 0; d < DRV; d++) tr_in[d] = ntr[d];
        drive_tracks();
        bus.img_valid = nv; m_val = nv;
        model_service();
    endtask

    task automatic end_check(input string name);
        chk({name, "_lba"}, bus.sd_lba, m_lba);
        chk({name, "_sec"}, bus.track_sec, m_sec);
        chk({name, "_drive"}, bus.track_drive, m_drv);
        chk({name, "_wait"}, bus.cpu_wait, 1'b0);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_req"}, {bus.sd_rd, bus.sd_wr}, '0);
        chk({name, "_pending"}, sb.size(), 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk_sys);
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (3) @(negedge clk_sys);
        chk({name, "_timeout"}, (n >= 3000), 1'b0);
        end_check(name);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_rd_wr"}, {bus.sd_rd, bus.sd_wr}, '0);
        chk({name, "_lba"}, bus.sd_lba, 0);
        chk({name, "_misc"}, {bus.track_sec, bus.track_drive, bus.cpu_wait, bus.busy}, 0);
    endtask

    // SD host: acks whichever drive requests, random hold and gap lengths.
    initial begin : sd_host
        int hold, gap, d;
        logic [DRV-1:0] req;
        bus.sd_ack = '0; hold = 0; gap = 0;
        forever begin
            @(negedge clk_sys);
            req = bus.sd_rd | bus.sd_wr;
            if (reset) begin
                bus.sd_ack = '0; hold = 0; gap = 0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    bus.sd_ack = '0;
                    gap = $urandom_range(0, 2);
                end
            end else if (gap > 0) begin
                gap--;
            end else if (req != '0) begin
                d = 0;
                for (int i = DRV-1; i >= 0; i--) if (req[i]) d = i;
                bus.sd_ack[d] = 1'b1;
                hold = $urandom_range(1, 3);
            end
        end
    end

    // Monitor: every ack rise marks a sector start; compare it with the scoreboard head.
    initial begin : monitor
        logic [DRV-1:0] prev, req;
        xfer_t got, exp;
        prev = '0;
        forever begin
            @(negedge clk_sys);
            #1;
            if (reset) begin
                prev = bus.sd_ack;
            end else begin
                if ((bus.sd_ack & ~prev) != '0) begin
                    n_starts++;
                    req = bus.sd_rd | bus.sd_wr;
                    chk("req_onehot", {($countones(req) == 1), ((bus.sd_rd & bus.sd_wr) == '0)}, 2'b11);
                    got.wr = |bus.sd_wr; got.drv = '0;
                    for (int i = 0; i < DRV; i++) if (req[i]) got.drv = 2'(i);
                    got.sec = bus.track_sec; got.lba = bus.sd_lba;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_sector: got wr=%0d drv=%0d sec=%0d lba=%0d expected none",
                                 got.wr, got.drv, got.sec, got.lba);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp || bus.track_drive !== exp.drv) begin
                            errors++;
                            $display("FAIL sector: got wr=%0d drv=%0d/%0d sec=%0d lba=%0d expected wr=%0d drv=%0d sec=%0d lba=%0d",
                                     got.wr, got.drv, bus.track_drive, got.sec, got.lba,
                                     exp.wr, exp.drv, exp.sec, exp.lba);
                        end
                    end
                    chk("sector_wait_busy", {bus.cpu_wait, bus.busy}, 2'b11);
                end
                prev = bus.sd_ack;
            end
        end
    end

    initial begin : watchdog
        #900000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, n, ntr[DRV];
        logic [DRV-1:0] dm, mm, nv;
        reset = 1'b1;
        bus.img_mounted = '0; bus.dirty_set = '0; bus.img_valid = 2'b11; m_val = 2'b11;
        bus2.track = '0; bus2.img_mounted = '0; bus2.dirty_set = '0; bus2.img_valid = 1'b1; bus2.sd_ack = '0;
        for (int d = 0; d < DRV; d++) tr_in[d] = 0;
        drive_tracks();
        model_reset();
        repeat (3) @(negedge clk_sys);
        check_all_zero("reset");
        @(posedge clk_sys); #2 reset = 1'b0;
        wait_done("idle_after_reset");

        apply('0, '0, '{5, 0}, 2'b11);              // single read, lba 65..77
        wait_done("read_track5");
        apply(2'b01, '0, '{6, 0}, 2'b11);           // dirty write-back then read
        wait_done("write_then_read");
        apply('0, '0, '{2, 9}, 2'b11);              // both drives at once
        wait_done("two_drives");
        apply(2'b10, '0, '{2, 9}, 2'b11);
        wait_done("dirty_drive1");
        apply('0, 2'b10, '{2, 9}, 2'b11);           // mount discards dirty: read only
        wait_done("mount_drive1");
        apply('0, '0, '{20, 9}, 2'b10);             // no image: no SD traffic
        wait_done("invalid_image");
        apply('0, 2'b01, '{20, 9}, 2'b11);
        wait_done("mount_drive0");

        // Reset in the middle of a read, with a dirty drive 0 that must be forgotten.
        apply(2'b01, '0, '{20, 9}, 2'b11);
        wait_done("dirty_before_reset");
        base = n_starts;
        apply('0, '0, '{20, 11}, 2'b11);
        n = 0;
        while (n_starts < base + 4 && n < 2000) begin @(negedge clk_sys); n++; end
        chk("reset_wait_timeout", (n >= 2000), 1'b0);
        @(posedge clk_sys); #2 reset = 1'b1;
        sb.delete();
        model_reset();
        #1 check_all_zero("reset_mid_xfer");
        for (int d = 0; d < DRV; d++) tr_in[d] = 0;
        drive_tracks();
        repeat (3) @(negedge clk_sys);
        @(posedge clk_sys); #2 reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        wait_done("after_reset_quiet");
        apply('0, '0, '{3, 0}, 2'b11);
        wait_done("after_reset_read");

        for (int it = 0; it < 30; it++) begin
            mm = ($urandom_range(0, 3) == 0) ? DRV'($urandom_range(0, 3)) : '0;
            dm = DRV'($urandom_range(0, 3)) & ~mm;
            nv = ($urandom_range(0, 4) == 0) ? DRV'($urandom_range(0, 3)) : 2'b11;
            for (int d = 0; d < DRV; d++)
                ntr[d] = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 63)) : tr_in[d];
            apply(dm, mm, ntr, nv);
            wait_done("random");
        end

        // Early CPU release variant: 3 sectors, track 2.
        @(negedge clk_sys);
        bus2.track = 4'd2;
        n = 0;
        while (bus2.sd_rd !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
        chk("wf0_req_timeout", (n >= 50), 1'b0);
        chk("wf0_wait_start", bus2.cpu_wait, 1'b1);
        chk("wf0_lba_start", bus2.sd_lba, 6);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_sys); bus2.sd_ack = 1'b1;
            @(negedge clk_sys); bus2.sd_ack = 1'b0;
            @(negedge clk_sys);
            if (s < 2) chk("wf0_wait_busy_mid", {bus2.cpu_wait, bus2.busy}, 2'b01);
        end
        chk("wf0_end", {bus2.busy, bus2.cpu_wait, bus2.sd_rd, bus2.track_sec}, {3'b000, 4'd3});
        chk("wf0_lba_end", bus2.sd_lba, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
